// File: rtl/taxi_pcie_us_vpd_mf_if.sv
// APB bus interface (taxi_apb_if) used by the multi-function PCIe VPD capability.
interface taxi_apb_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned STRB_W   = DATA_W/8,
   parameter int unsigned PAUSER_W = 1,
   parameter int unsigned PWUSER_W = 1
) ();
   logic [ADDR_W-1:0]   paddr;
   logic [2:0]          pprot;
   logic                psel;
   logic                penable;
   logic                pwrite;
   logic [DATA_W-1:0]   pwdata;
   logic [STRB_W-1:0]   pstrb;
   logic [PAUSER_W-1:0] pauser;
   logic [PWUSER_W-1:0] pwuser;
   logic                pready;
   logic [DATA_W-1:0]   prdata;
   logic                pslverr;

   modport mst (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
      input  pready, prdata, pslverr
   );

   modport slv (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/taxi_pcie_us_vpd_mf.sv
// Multi-function PCIe VPD capability for UltraScale config-extend, bridging to APB storage.
// Optional ACCESS-phase timeout enabled by defining TAXI_PCIE_VPD_TIMEOUT_EN.
module taxi_pcie_us_vpd_mf #(
   parameter int unsigned FUNC_CNT   = 4,
   parameter logic [7:0]  CAP_ID     = 8'h03,
   parameter logic [7:0]  CAP_OFFSET = 8'hB0,
   parameter logic [7:0]  CAP_NEXT   = 8'h00,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   taxi_apb_if.mst     m_apb,
   input  logic        cfg_ext_read_received,
   input  logic        cfg_ext_write_received,
   input  logic [9:0]  cfg_ext_register_number,
   input  logic [7:0]  cfg_ext_function_number,
   input  logic [31:0] cfg_ext_write_data,
   input  logic [3:0]  cfg_ext_write_byte_enable,
   output logic [31:0] cfg_ext_read_data,
   output logic        cfg_ext_read_data_valid
);

   localparam int unsigned FW = (FUNC_CNT > 1) ? $clog2(FUNC_CNT) : 1;
   localparam int unsigned DW = $bits(m_apb.pwdata);
   localparam int unsigned AW = $bits(m_apb.paddr);
   localparam logic [9:0]  REG0 = 10'(CAP_OFFSET >> 2);
   localparam logic [9:0]  REG1 = REG0 + 10'd1;

   if (DW != 32 || AW < 15 + $clog2(FUNC_CNT)) begin : g_bad_cfg
      $fatal(1, "taxi_pcie_us_vpd_mf: APB DATA_W must be 32 and ADDR_W >= 15+clog2(FUNC_CNT)");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

   state_t              state_q, state_d;
   logic [14:0]         addr_q [FUNC_CNT];
   logic [31:0]         data_q [FUNC_CNT];
   logic [FUNC_CNT-1:0] flag_q, pending_q, busy_q;
   logic [FW-1:0]       rr_q, cur_q;
   logic                psel_q, penable_q, pwrite_q;
   logic [AW-1:0]       paddr_q;
   logic [31:0]         pwdata_q;
   logic                rd_valid_q;
   logic [31:0]         rd_data_q;

   logic                fn_ok_c, is_reg0_c, is_reg1_c, wr_ok_c;
   logic [FW-1:0]       fn_c;
   logic                grant_vld_c;
   logic [FW-1:0]       grant_c;
   logic                timeout_c, done_c, err_c;

   assign fn_ok_c   = {1'b0, cfg_ext_function_number} < 9'(FUNC_CNT);
   assign fn_c      = FW'(cfg_ext_function_number);
   assign is_reg0_c = cfg_ext_register_number == REG0;
   assign is_reg1_c = cfg_ext_register_number == REG1;
   assign wr_ok_c   = cfg_ext_write_received && fn_ok_c && !pending_q[fn_c] && !busy_q[fn_c];

   // Round-robin: first pending function at or after rr_q, wrapping.
   always_comb begin
      int idx;
      grant_vld_c = 1'b0;
      grant_c     = '0;
      idx         = 0;
      for (int i = int'(FUNC_CNT) - 1; i >= 0; i--) begin
         idx = (int'(rr_q) + i) % int'(FUNC_CNT);
         if (pending_q[idx]) begin
            grant_vld_c = 1'b1;
            grant_c     = FW'(idx);
         end
      end
   end

`ifdef TAXI_PCIE_VPD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt_q;

   always_ff @(posedge clk) begin
      if (rst || state_q != ST_ACCESS) to_cnt_q <= '0;
      else                             to_cnt_q <= to_cnt_q + TW'(1);
   end

   assign timeout_c = (state_q == ST_ACCESS) && !m_apb.pready && (to_cnt_q == TW'(TIMEOUT - 1));
`else
   assign timeout_c = 1'b0;
`endif

   assign done_c = (state_q == ST_ACCESS) && (m_apb.pready || timeout_c);
   assign err_c  = m_apb.pslverr || timeout_c;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (grant_vld_c) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (done_c) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Per-function register sets, config response and APB request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         flag_q     <= '0;
         pending_q  <= '0;
         busy_q     <= '0;
         rr_q       <= '0;
         cur_q      <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         for (int i = 0; i < int'(FUNC_CNT); i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         rd_valid_q <= cfg_ext_read_received && fn_ok_c && (is_reg0_c || is_reg1_c);
         if (cfg_ext_read_received && fn_ok_c) begin
            if (is_reg0_c)      rd_data_q <= {flag_q[fn_c], addr_q[fn_c], CAP_NEXT, CAP_ID};
            else if (is_reg1_c) rd_data_q <= data_q[fn_c];
         end

         if (wr_ok_c && is_reg0_c) begin
            addr_q[fn_c]    <= cfg_ext_write_data[30:16];
            flag_q[fn_c]    <= cfg_ext_write_data[31];
            pending_q[fn_c] <= 1'b1;
         end
         if (wr_ok_c && is_reg1_c) data_q[fn_c] <= cfg_ext_write_data;

         if (state_q == ST_IDLE && grant_vld_c) begin
            pending_q[grant_c] <= 1'b0;
            busy_q[grant_c]    <= 1'b1;
            cur_q              <= grant_c;
            rr_q               <= (grant_c == FW'(FUNC_CNT - 1)) ? '0 : grant_c + FW'(1);
            paddr_q            <= AW'(addr_q[grant_c]) | (AW'(grant_c) << 15);
            pwrite_q           <= flag_q[grant_c];
            pwdata_q           <= data_q[grant_c];
         end

         if (done_c) begin
            busy_q[cur_q] <= 1'b0;
            if (pwrite_q) begin
               flag_q[cur_q] <= 1'b0;
            end else begin
               flag_q[cur_q] <= 1'b1;
               data_q[cur_q] <= err_c ? 32'hFFFF_FFFF : m_apb.prdata;
            end
         end

         psel_q    <= state_d != ST_IDLE;
         penable_q <= state_d == ST_ACCESS;
      end
   end

   assign m_apb.paddr   = paddr_q;
   assign m_apb.pprot   = 3'b010;
   assign m_apb.psel    = psel_q;
   assign m_apb.penable = penable_q;
   assign m_apb.pwrite  = pwrite_q;
   assign m_apb.pwdata  = pwdata_q;
   assign m_apb.pstrb   = '1;
   assign m_apb.pauser  = '0;
   assign m_apb.pwuser  = '0;

   assign cfg_ext_read_data       = rd_data_q;
   assign cfg_ext_read_data_valid = rd_valid_q;

   // Byte enables carry no meaning for VPD; TIMEOUT is idle unless the timeout is built in.
   logic unused_c;
   assign unused_c = ^{cfg_ext_write_byte_enable, 32'(TIMEOUT)};

endmodule

// File: tb/tb_taxi_pcie_us_vpd_mf.sv
// Scoreboard bench for taxi_pcie_us_vpd_mf: random config traffic against a per-function model,
// with an APB slave that checks round-robin order and requests.
module tb_taxi_pcie_us_vpd_mf;
   localparam int         N    = 4;
   localparam logic [9:0] REG0 = 10'h2C;
   localparam logic [9:0] REG1 = 10'h2D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_rcv = 1'b0, wr_rcv = 1'b0;
   logic [9:0]  reg_num = '0;
   logic [7:0]  fn = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic [31:0] rd_data;
   logic        rd_valid;

   taxi_apb_if #(.DATA_W(32), .ADDR_W(20)) apb ();

   taxi_pcie_us_vpd_mf #(.FUNC_CNT(N)) dut (
      .clk(clk), .rst(rst), .m_apb(apb),
      .cfg_ext_read_received(rd_rcv), .cfg_ext_write_received(wr_rcv),
      .cfg_ext_register_number(reg_num), .cfg_ext_function_number(fn),
      .cfg_ext_write_data(wdata), .cfg_ext_write_byte_enable(be),
      .cfg_ext_read_data(rd_data), .cfg_ext_read_data_valid(rd_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   // Model: per-function state; m_out 0 = idle, 1 = requested, 2 = on the bus.
   logic [14:0] m_addr [N];
   logic        m_flag [N];
   logic [31:0] m_data [N];
   int          m_out  [N];
   int          m_stamp[N];
   int          m_rr = 0;

   typedef struct { logic [31:0] d; int c; } rd_exp_t;
   rd_exp_t exp_rd_q[$];
   int      order_q[$];

   bit          hold = 1'b0;
   bit          force_rd = 1'b0;
   logic [31:0] force_data = '0;
   logic [19:0] last_paddr = '0;
   logic [31:0] last_pwdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] m_reg0(input int f);
      return {m_flag[f], m_addr[f], 8'h00, 8'h03};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_addr[i] = '0; m_flag[i] = 1'b0; m_data[i] = '0; m_out[i] = 0; m_stamp[i] = 0;
      end
      m_rr = 0;
   endtask

   task automatic cfg_rd(input int f, input logic [9:0] r, input logic [31:0] lit, input bit use_lit);
      rd_exp_t e;
      @(negedge clk);
      rd_rcv = 1'b1; fn = 8'(f); reg_num = r;
      if (f < N && (r == REG0 || r == REG1)) begin
         e.d = use_lit ? lit : ((r == REG0) ? m_reg0(f) : m_data[f]);
         e.c = cyc + 1;
         exp_rd_q.push_back(e);
      end
      @(posedge clk); #1;
      rd_rcv = 1'b0;
   endtask

   task automatic cfg_wr(input int f, input logic [9:0] r, input logic [31:0] d);
      @(negedge clk);
      wr_rcv = 1'b1; fn = 8'(f); reg_num = r; wdata = d; be = 4'($urandom);
      if (f < N && m_out[f] == 0) begin
         if (r == REG0) begin
            m_addr[f] = d[30:16]; m_flag[f] = d[31]; m_out[f] = 1; m_stamp[f] = cyc;
         end else if (r == REG1) begin
            m_data[f] = d;
         end
      end
      @(posedge clk); #1;
      wr_rcv = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit idle;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         idle = (exp_rd_q.size() == 0);
         for (int f = 0; f < N; f++) if (m_out[f] != 0) idle = 1'b0;
         if (idle) return;
      end
      checks++; errors++;
      $display("FAIL %s timed out waiting for idle (cycle %0d)", name, cyc);
   endtask

   task automatic apply_done(input int f, input bit err, input logic [31:0] rdata);
      if (m_flag[f]) m_flag[f] = 1'b0;
      else begin
         m_flag[f] = 1'b1;
         m_data[f] = err ? 32'hFFFF_FFFF : rdata;
      end
      m_out[f] = 0;
   endtask

   // Read-response monitor.
   always @(negedge clk) begin
      rd_exp_t e;
      if (!rst && rd_valid) begin
         if (exp_rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_spurious actual=valid data %h expected=no response (cycle %0d)", rd_data, cyc);
         end else begin
            e = exp_rd_q.pop_front();
            chk("rd_data", rd_data, e.d);
            chk("rd_latency", 32'(cyc), 32'(e.c));
         end
      end
   end

   // APB slave and request checker.
   initial begin
      int cur, wait_n, acc_n, exp_g;
      bit prev_psel, expect_access, now_psel, err;
      logic [31:0] rdata;
      cur = 0; wait_n = 0; acc_n = 0; prev_psel = 0; expect_access = 0;
      apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
      forever begin
         @(negedge clk);
         apb.pready = 1'b0; apb.pslverr = 1'b0;
         now_psel = apb.psel;
         if (rst) begin
            expect_access = 0;
         end else begin
            if (expect_access) begin
               chk("apb_setup_to_access", 32'(apb.psel && apb.penable), 32'd1);
               expect_access = 0;
            end
            if (apb.psel && !apb.penable) begin
               chk("apb_idle_gap", 32'(prev_psel), 32'd0);
               exp_g = -1;
               for (int i = N - 1; i >= 0; i--) begin
                  int f;
                  f = (m_rr + i) % N;
                  if (m_out[f] == 1 && m_stamp[f] <= cyc - 2) exp_g = f;
               end
               if (exp_g < 0) begin
                  checks++; errors++;
                  $display("FAIL apb_grant actual=paddr %h expected=no transfer (cycle %0d)", apb.paddr, cyc);
                  exp_g = int'(apb.paddr[16:15]);
               end
               chk("apb_paddr", 32'(apb.paddr), 32'((20'(exp_g) << 15) | 20'(m_addr[exp_g])));
               chk("apb_pwrite", 32'(apb.pwrite), 32'(m_flag[exp_g]));
               chk("apb_pwdata", apb.pwdata, m_data[exp_g]);
               chk("apb_pstrb_pprot", {apb.pstrb, 1'b0, apb.pprot}, {4'hF, 1'b0, 3'b010});
               chk("apb_user", 32'({apb.pauser, apb.pwuser}), 32'd0);
               last_paddr = apb.paddr; last_pwdata = apb.pwdata;
               order_q.push_back(exp_g);
               m_out[exp_g] = 2;
               m_rr = (exp_g + 1) % N;
               cur = exp_g;
               wait_n = $urandom_range(0, 3);
               acc_n = 0;
               expect_access = 1;
            end else if (apb.psel && apb.penable) begin
               acc_n++;
               if (!hold && wait_n <= 0) begin
                  rdata = force_rd ? force_data : $urandom;
                  err = force_rd ? 1'b0 : ($urandom_range(0, 7) == 0);
                  apb.pready = 1'b1; apb.prdata = rdata; apb.pslverr = err;
                  @(posedge clk); #1;
                  apply_done(cur, err, rdata);
                  now_psel = 1'b1;
`ifdef TAXI_PCIE_VPD_TIMEOUT_EN
               end else if (hold && acc_n == 1024) begin
                  @(posedge clk); #1;
                  apply_done(cur, 1'b1, 32'h0);
                  chk("timeout_psel_drop", 32'(apb.psel), 32'd0);
                  now_psel = 1'b1;
`endif
               end else begin
                  wait_n--;
               end
            end
         end
         prev_psel = now_psel;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_valid", 32'(rd_valid), 32'd0);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_psel_penable", 32'({apb.psel, apb.penable}), 32'd0);
      for (int f = 0; f < N; f++) begin
         cfg_rd(f, REG0, 32'h0000_0003, 1'b1);
         cfg_rd(f, REG1, 32'h0, 1'b1);
      end

      // f0 APB write
      cfg_wr(0, REG1, 32'hDEAD_BEEF);
      cfg_wr(0, REG0, 32'h8012_0000);
      wait_idle("t_write", 200);
      chk("t_write_paddr", 32'(last_paddr), 32'h0000_0012);
      chk("t_write_pwdata", last_pwdata, 32'hDEAD_BEEF);
      cfg_rd(0, REG0, 32'h0012_0003, 1'b1);

      // f2 APB read with known data
      force_rd = 1'b1; force_data = 32'h1122_3344;
      cfg_wr(2, REG0, 32'h0034_0000);
      wait_idle("t_read", 200);
      force_rd = 1'b0;
      chk("t_read_paddr", 32'(last_paddr), 32'h0001_0034);
      cfg_rd(2, REG0, 32'h8034_0003, 1'b1);
      cfg_rd(2, REG1, 32'h1122_3344, 1'b1);

      // f1 and f3 requested back to back
      order_q.delete();
      cfg_wr(1, REG0, 32'h0101_0000);
      cfg_wr(3, REG0, 32'h8303_0000);
      wait_idle("t_rr", 200);
      chk("t_rr_count", 32'(order_q.size()), 32'd2);
      if (order_q.size() == 2) begin
         chk("t_rr_first", 32'(order_q[0]), 32'd1);
         chk("t_rr_second", 32'(order_q[1]), 32'd3);
      end
      cfg_rd(1, REG0, m_reg0(1), 1'b0);
      chk("t_rr_f1_flag", 32'(m_flag[1]), 32'd1);
      cfg_rd(3, REG0, 32'h0303_0003, 1'b1);

      // write to REG1 while busy is dropped
      hold = 1'b1;
      cfg_wr(0, REG0, 32'h8055_0000);
      repeat (6) @(negedge clk);
      cfg_wr(0, REG1, 32'hCAFE_F00D);
      cfg_rd(0, REG1, 32'hDEAD_BEEF, 1'b1);
      hold = 1'b0;
      wait_idle("t_busy", 200);

      // out-of-range function and register get no response
      cfg_rd(N, REG0, 32'h0, 1'b0);
      @(negedge clk);
      chk("t_badfn_no_valid", 32'(rd_valid), 32'd0);
      cfg_rd(0, REG1 + 10'd1, 32'h0, 1'b0);
      @(negedge clk);
      chk("t_badreg_no_valid", 32'(rd_valid), 32'd0);

      // random traffic
      for (int n = 0; n < 500; n++) begin
         int f, op;
         logic [9:0] r;
         f  = ($urandom_range(0, 15) == 0) ? N : $urandom_range(0, N - 1);
         op = $urandom_range(0, 5);
         case (op)
            0: cfg_wr(f, REG0, $urandom);
            1: cfg_wr(f, REG1, $urandom);
            2: cfg_rd(f, REG0, 32'h0, 1'b0);
            3: cfg_rd(f, REG1, 32'h0, 1'b0);
            4: begin
               r = 10'($urandom);
               if (r == REG0 || r == REG1) r = 10'h000;
               if ($urandom_range(0, 1) == 0) cfg_rd(f, r, 32'h0, 1'b0);
               else cfg_wr(f, r, $urandom);
            end
            default: @(negedge clk);
         endcase
      end
      wait_idle("t_random_drain", 500);
      for (int f = 0; f < N; f++) begin
         cfg_rd(f, REG0, 32'h0, 1'b0);
         cfg_rd(f, REG1, 32'h0, 1'b0);
      end
      wait_idle("t_random_final", 50);

`ifdef TAXI_PCIE_VPD_TIMEOUT_EN
      hold = 1'b1;
      cfg_wr(1, REG0, 32'h0077_0000);
      wait_idle("t_timeout", 1200);
      hold = 1'b0;
      cfg_rd(1, REG1, 32'hFFFF_FFFF, 1'b1);
      cfg_rd(1, REG0, 32'h8077_0003, 1'b1);
      wait_idle("t_timeout_rd", 50);
`endif

      // reset in the middle of ACCESS
      hold = 1'b1;
      cfg_wr(3, REG0, 32'h0042_0000);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (apb.psel && apb.penable) seen = 1'b1;
         end
         chk("t_rst_reach_access", 32'(seen), 32'd1);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("t_rst_psel", 32'(apb.psel), 32'd0);
      chk("t_rst_penable", 32'(apb.penable), 32'd0);
      chk("t_rst_valid", 32'(rd_valid), 32'd0);
      rst = 1'b0;
      hold = 1'b0;
      model_reset();
      exp_rd_q.delete();
      cfg_rd(3, REG0, 32'h0000_0003, 1'b1);
      cfg_rd(3, REG1, 32'h0, 1'b1);
      wait_idle("t_rst_after", 50);
      repeat (5) @(negedge clk);
      chk("t_rst_no_transfer", 32'(apb.psel), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
